// File: rtl/regfile_pkg.sv
// Shared sizes and types for the register-file write-back scheduler.
// Top-level parameters default to these values.
package regfile_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int CNT_WIDTH      = 2;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     reg_data_t;
  typedef logic [CNT_WIDTH-1:0]      wb_cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among asserted requests.
// After a grant to i, the search for the next grant starts at i+1.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // Visit requesters in priority order (ptr, ptr+1, ... wrapping) and take the first.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            ((int'(ptr_q) + off == i) || (int'(ptr_q) + off == i + N))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port among NUM_REQ producers and keeps a
// per-register outstanding-write scoreboard for RAW stall detection.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = regfile_pkg::CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]       issue_rd,
  output logic                            issue_ready,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [REG_ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            reg_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]       rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]       rs2_addr,
  output logic                            rs1_busy,
  output logic                            rs2_busy,
  output logic [NUM_REGS-1:0]             busy_mask,
  output logic                            wb_underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0]            grant;
  logic                          sel_any;
  reg_addr_t                     sel_addr;
  logic [DATA_WIDTH-1:0]         sel_data;

  reg_addr_t                     rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]         rd_data_q, rd_data_d;
  logic                          wr_en_q, wr_en_d;
  logic                          underflow_q, underflow_d;

  logic [NUM_REGS*CNT_WIDTH-1:0] cnt_flat;
  logic [NUM_REGS-1:0]           uf_evt;
  logic                          issue_fire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_any  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_any  = 1'b1;
        sel_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A granted write to x0 is consumed but never reaches the register file.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wr_en_d   = 1'b0;
    if (sel_any) begin
      rd_addr_d = sel_addr;
      rd_data_d = sel_data;
      wr_en_d   = (sel_addr != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      wr_en_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      wr_en_q     <= wr_en_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_addr          = rd_addr_q;
  assign rd_data          = rd_data_q;
  assign reg_write_enable = wr_en_q;

  assign issue_fire = issue_valid && issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_flat[0 +: CNT_WIDTH] = '0;
        assign busy_mask[0]             = 1'b0;
        assign uf_evt[0]                = 1'b0;
      end else begin : g_reg
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 inc, dec;

        assign inc = issue_fire && (issue_rd == reg_addr_t'(gi));
        assign dec = wr_en_q && (rd_addr_q == reg_addr_t'(gi));

        // Simultaneous issue and commit cancel; a commit with nothing pending saturates at 0.
        always_comb begin
          cnt_d = cnt_q;
          if (inc && !dec) begin
            cnt_d = cnt_q + 1'b1;
          end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign busy_mask[gi]                       = (cnt_q != '0);
        assign uf_evt[gi]                          = dec && (cnt_q == '0);
      end
    end
  endgenerate

  assign underflow_d  = underflow_q | (|uf_evt);
  assign wb_underflow = underflow_q;

  // Depends only on issue_rd and counter state, never on the write-back requests.
  assign issue_ready = (issue_rd == '0) ||
                       (cnt_flat[int'(issue_rd)*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX);

  assign rs1_busy = (rs1_addr != '0) && busy_mask[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && busy_mask[rs2_addr];

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 integer register file: arbitrates the single register-file write port between NUM_REQ producers (ALU, load unit, …) and keeps a per-register pending-write scoreboard so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file's `rd_addr`/`rd_data`/`reg_write_enable` inputs. Output to the register file is registered; the scoreboard clears on the same edge the register file commits.

## Interface
- NUM_REQ, 2, number of write-back requesters (2..4)
- DATA_WIDTH, 32, register data width
- CNT_WIDTH, 2, per-register outstanding-write counter width (max 3 outstanding)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode claims a destination register this cycle
- issue_rd  in  5  claimed destination register
- issue_ready  out  1  claim accepted; low when count[issue_rd] is at max
- req_valid  in  NUM_REQ  requester i holds a result
- req_addr  in  NUM_REQ×5  destination register per requester
- req_data  in  NUM_REQ×DATA_WIDTH  result per requester
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid && ready
- rd_addr  out  5  to register file
- rd_data  out  DATA_WIDTH  to register file
- reg_write_enable  out  1  to register file
- rs1_addr, rs2_addr  in  5 each  decode source registers
- rs1_busy, rs2_busy  out  1 each  source has a pending write
- busy_mask  out  32  bit r = count[r] != 0
- wb_underflow  out  1  sticky protocol error flag

## Operation
- Arbiter: round-robin over asserted req_valid; at most one req_ready high per cycle; req_ready[i] only when req_valid[i]. After a grant to i, priority order starts at i+1 (mod NUM_REQ). After reset, requester 0 has highest priority.
- Accepted transfer loads rd_addr/rd_data on the next edge; reg_write_enable=1 for exactly that following cycle unless req_addr==0 (accepted, no write, no counter change).
- Scoreboard: 32 counters of CNT_WIDTH bits; x0 counter is constant 0.
- Increment count[issue_rd] on edge with issue_valid && issue_ready && issue_rd!=0.
- Decrement count[rd_addr] on edge where reg_write_enable=1 (the edge the register file commits).
- Same register incremented and decremented on one edge: net unchanged.
- issue_ready = (issue_rd==0) || count[issue_rd] != max; a simultaneous decrement does not relax it.
- Decrement of a zero counter: counter stays 0, wb_underflow set and held until reset.
- rsN_busy = (rsN_addr!=0) && count[rsN_addr]!=0, combinational.

## Timing
- Reset values: rd_addr=0, rd_data=0, reg_write_enable=0, all counters 0, busy_mask=0, wb_underflow=0, RR pointer → requester 0. Reset mid-transfer discards the pending write.
- req_ready, issue_ready, rsN_busy: combinational from inputs and state (no combinational path from req_* to issue_ready).
- Latency: grant at cycle N → reg_write_enable high in N+1 → data in register file and busy cleared at end of N+1; consumer reads correct value in N+2.
- Throughput: one write-back per cycle; back-to-back grants produce consecutive reg_write_enable cycles.
- Issue and write-back to the same register in the same cycle are independent events; no bypass from req_data to readers.

## Structure
- Package regfile_pkg: NUM_REGS=32, REG_ADDR_WIDTH=5, DATA_WIDTH, CNT_WIDTH, typedef reg_addr_t, reg_data_t, wb_cnt_t.
- Sub-module rr_arbiter (parameter N): req vector in, one-hot grant out, rotating pointer updated on any grant.
- Top: arbiter instance, output register stage, counter array, busy decode.

## Test plan
- Reset: assert rst_n=0 mid-stream with req_valid=2'b11 → all outputs 0, busy_mask=0, next grant goes to requester 0.
- Contention: req_valid=2'b11 held 4 cycles, addrs x5/x6 → grants 0,1,0,1; reg_write_enable high 4 consecutive cycles, rd_addr 5,6,5,6.
- Scoreboard: issue x7 three times → issue_ready=0 for x7, busy_mask[7]=1; one write-back to x7 → count 2 after the reg_write_enable cycle, issue_ready=1.
- RAW timing: issue x3, grant write x3=0xDEADBEEF at cycle N → rs1_busy (rs1_addr=3) high through N+1, low at N+2, register file reads 0xDEADBEEF.
- x0: issue x0 and write x0=0x1234 → issue_ready=1, req_ready=1, reg_write_enable stays 0, busy_mask unchanged.
- Underflow/simultaneous: write-back to x9 with count 0 → wb_underflow=1 sticky; issue x4 on the same edge x4 decrements from 1 → count stays 1.
